// File: rtl/ft600_pkg.sv
// ft600_pkg: shared constants and types for the FT600 device-side model.
//   ERR_*        bit positions inside the sticky err vector
//   ERR_W        width of the err vector
//   ft600_word_t {be,data} word as carried by the FIFOs at the default bus width
package ft600_pkg;

  localparam int ERR_W        = 4;
  localparam int ERR_RD_NO_OE = 0;  // read strobe without output enable
  localparam int ERR_WR_OE    = 1;  // write strobe while device owns the bus
  localparam int ERR_UNDERRUN = 2;  // read attempted while rxf_n high
  localparam int ERR_OVERRUN  = 3;  // write attempted while txe_n high

  localparam int FT_DW  = 16;
  localparam int FT_BEW = FT_DW / 8;

  typedef struct packed {
    logic [FT_BEW-1:0] be;
    logic [FT_DW-1:0]  data;
  } ft600_word_t;

endpackage

// File: rtl/ft600_dev_fifo.sv
// ft600_dev_fifo: single-clock first-word-fall-through FIFO.
//   clk, rst_n  clock / synchronous active-low reset (flushes contents)
//   wr_en       push wr_data (ignored when full)
//   rd_en       pop head (ignored when empty); rd_data always shows the head
//   empty/full  registered flags
//   free_nxt    free entries after this cycle's push/pop (for registered thresholds)
module ft600_dev_fifo
  import ft600_pkg::*;
#(
  parameter int W     = 18,
  parameter int DEPTH = 512
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wr_en,
  input  logic [W-1:0]             wr_data,
  input  logic                     rd_en,
  output logic [W-1:0]             rd_data,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   free_nxt
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic          empty_q, empty_d, full_q, full_d;
  logic          do_wr, do_rd;

  always_comb begin
    do_wr    = wr_en && !full_q;
    do_rd    = rd_en && !empty_q;
    wr_ptr_d = wr_ptr_q + AW'(do_wr);
    rd_ptr_d = rd_ptr_q + AW'(do_rd);
    cnt_d    = cnt_q;
    if (do_wr && !do_rd)      cnt_d = cnt_q + (AW+1)'(1);
    else if (!do_wr && do_rd) cnt_d = cnt_q - (AW+1)'(1);
    // flags come from the next count so they are valid right after the edge
    empty_d  = (cnt_d == '0);
    full_d   = (cnt_d == (AW+1)'(DEPTH));
    free_nxt = (AW+1)'(DEPTH) - cnt_d;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      empty_q  <= 1'b1;
      full_q   <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      empty_q  <= empty_d;
      full_q   <= full_d;
    end
  end

  // storage is not reset; pointers define validity
  always_ff @(posedge clk) begin
    if (do_wr) mem_q[wr_ptr_q] <= wr_data;
  end

  assign rd_data = mem_q[rd_ptr_q];
  assign empty   = empty_q;
  assign full    = full_q;

endmodule

// File: rtl/ft600_device_model.sv
// ft600_device_model: chip-side responder for the FT600 245 synchronous FIFO bus.
//   clk, rst_n              bus clock / synchronous active-low reset
//   ft_data, ft_be          bidirectional bus, driven by us only while ft_oe_n=0
//   ft_rxf_n, ft_txe_n      data-available / space-available flags (registered)
//   ft_rd_n, ft_wr_n, ft_oe_n  master strobes
//   h2f_*                   host-side push stream feeding bus reads
//   f2h_*                   fwft stream of words captured from bus writes, {be,data}
//   err                     sticky protocol violations (bit map in ft600_pkg)
//   rd_count, wr_count      wrapping counts of bus reads / accepted bus writes
module ft600_device_model
  import ft600_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int H2F_DEPTH  = 512,
  parameter int F2H_DEPTH  = 512,
  parameter int TXE_MARGIN = 1
) (
  input  logic                             clk,
  input  logic                             rst_n,
  inout  wire  [DATA_WIDTH-1:0]            ft_data,
  inout  wire  [DATA_WIDTH/8-1:0]          ft_be,
  output logic                             ft_rxf_n,
  output logic                             ft_txe_n,
  input  logic                             ft_rd_n,
  input  logic                             ft_wr_n,
  input  logic                             ft_oe_n,
  input  logic [DATA_WIDTH-1:0]            h2f_data,
  input  logic [DATA_WIDTH/8-1:0]          h2f_be,
  input  logic                             h2f_valid,
  output logic                             h2f_ready,
  output logic [DATA_WIDTH+DATA_WIDTH/8-1:0] f2h_data,
  output logic                             f2h_valid,
  input  logic                             f2h_ready,
  output logic [ERR_W-1:0]                 err,
  output logic [31:0]                      rd_count,
  output logic [31:0]                      wr_count
);

  localparam int BEW    = DATA_WIDTH / 8;
  localparam int WW     = DATA_WIDTH + BEW;
  localparam int H2F_AW = $clog2(H2F_DEPTH);
  localparam int F2H_AW = $clog2(F2H_DEPTH);

  logic [WW-1:0]    h2f_head, f2h_head;
  logic             h2f_empty, h2f_full, f2h_empty, f2h_full;
  logic [H2F_AW:0]  h2f_free_nxt;
  logic [F2H_AW:0]  f2h_free_nxt;
  logic             h2f_push, rd_pop, wr_cap, f2h_pop;

  logic             txe_n_q, txe_n_d;
  logic [ERR_W-1:0] err_q, err_d;
  logic [31:0]      rd_count_q, rd_count_d, wr_count_q, wr_count_d;

  assign h2f_ready = rst_n && !h2f_full;
  assign h2f_push  = h2f_valid && h2f_ready;

  ft600_dev_fifo #(.W(WW), .DEPTH(H2F_DEPTH)) u_h2f (
    .clk      (clk),
    .rst_n    (rst_n),
    .wr_en    (h2f_push),
    .wr_data  ({h2f_be, h2f_data}),
    .rd_en    (rd_pop),
    .rd_data  (h2f_head),
    .empty    (h2f_empty),
    .full     (h2f_full),
    .free_nxt (h2f_free_nxt)
  );

  ft600_dev_fifo #(.W(WW), .DEPTH(F2H_DEPTH)) u_f2h (
    .clk      (clk),
    .rst_n    (rst_n),
    .wr_en    (wr_cap),
    .wr_data  ({ft_be, ft_data}),
    .rd_en    (f2h_pop),
    .rd_data  (f2h_head),
    .empty    (f2h_empty),
    .full     (f2h_full),
    .free_nxt (f2h_free_nxt)
  );

  always_comb begin
    // rxf_n is the registered H2F empty flag, so qualifying on it matches what the master saw
    rd_pop  = !ft_rd_n && !ft_oe_n && !h2f_empty;
    wr_cap  = !ft_wr_n && ft_oe_n && !txe_n_q;
    f2h_pop = !f2h_empty && f2h_ready;
    // threshold on post-update occupancy keeps txe_n registered yet exact
    txe_n_d = (f2h_free_nxt <= (F2H_AW+1)'(TXE_MARGIN));

    err_d = err_q;
    if (!ft_rd_n && ft_oe_n)               err_d[ERR_RD_NO_OE] = 1'b1;
    if (!ft_wr_n && !ft_oe_n)              err_d[ERR_WR_OE]    = 1'b1;
    if (!ft_rd_n && !ft_oe_n && h2f_empty) err_d[ERR_UNDERRUN] = 1'b1;
    if (!ft_wr_n && txe_n_q)               err_d[ERR_OVERRUN]  = 1'b1;

    rd_count_d = rd_count_q + 32'(rd_pop);
    wr_count_d = wr_count_q + 32'(wr_cap);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      txe_n_q    <= 1'b1;
      err_q      <= '0;
      rd_count_q <= '0;
      wr_count_q <= '0;
    end else begin
      txe_n_q    <= txe_n_d;
      err_q      <= err_d;
      rd_count_q <= rd_count_d;
      wr_count_q <= wr_count_d;
    end
  end

  // an idle bus with oe_n low shows zeros rather than stale storage
  assign ft_data = !ft_oe_n ? (h2f_empty ? '0 : h2f_head[DATA_WIDTH-1:0]) : 'z;
  assign ft_be   = !ft_oe_n ? (h2f_empty ? '0 : h2f_head[WW-1:DATA_WIDTH]) : 'z;

  assign ft_rxf_n  = h2f_empty;
  assign ft_txe_n  = txe_n_q;
  assign f2h_data  = f2h_head;
  assign f2h_valid = !f2h_empty;
  assign err       = err_q;
  assign rd_count  = rd_count_q;
  assign wr_count  = wr_count_q;

  logic unused_fifo_sigs;
  assign unused_fifo_sigs = ^{h2f_free_nxt, f2h_full};

endmodule

// File: tb/tb_ft600_device_model.sv
module tb_ft600_device_model;
  import ft600_pkg::*;

  localparam int DW     = 16;
  localparam int BEW    = 2;
  localparam int DEPTH  = 512;
  localparam int MARGIN = 1;
  localparam int N_LOOP = 4096;

  logic clk = 1'b0;
  logic rst_n;
  wire  [DW-1:0]  ft_data;
  wire  [BEW-1:0] ft_be;
  logic [DW-1:0]  m_data;
  logic [BEW-1:0] m_be;
  logic ft_rxf_n, ft_txe_n, ft_rd_n, ft_wr_n, ft_oe_n;
  logic [DW-1:0]  h2f_data;
  logic [BEW-1:0] h2f_be;
  logic h2f_valid, h2f_ready;
  logic [DW+BEW-1:0] f2h_data;
  logic f2h_valid, f2h_ready;
  logic [3:0]  err;
  logic [31:0] rd_count, wr_count;

  int pass_cnt = 0;
  int total_cnt = 0;
  ft600_word_t h2f_q[$];
  ft600_word_t f2h_q[$];
  logic [31:0] exp_rd, exp_wr;

  // master drives the bus whenever it does not hand it to the device
  assign ft_data = ft_oe_n ? m_data : 'z;
  assign ft_be   = ft_oe_n ? m_be   : 'z;

  always #5 clk = ~clk;

  ft600_device_model dut (
    .clk(clk), .rst_n(rst_n), .ft_data(ft_data), .ft_be(ft_be),
    .ft_rxf_n(ft_rxf_n), .ft_txe_n(ft_txe_n), .ft_rd_n(ft_rd_n), .ft_wr_n(ft_wr_n),
    .ft_oe_n(ft_oe_n), .h2f_data(h2f_data), .h2f_be(h2f_be), .h2f_valid(h2f_valid),
    .h2f_ready(h2f_ready), .f2h_data(f2h_data), .f2h_valid(f2h_valid),
    .f2h_ready(f2h_ready), .err(err), .rd_count(rd_count), .wr_count(wr_count)
  );

  // inputs change at posedge+1, outputs sampled at posedge+1 (registered) or +3
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    ft_rd_n = 1'b1; ft_wr_n = 1'b1; ft_oe_n = 1'b1;
    h2f_valid = 1'b0; f2h_ready = 1'b0;
    m_data = '0; m_be = '0; h2f_data = '0; h2f_be = '0;
  endtask

  task automatic do_reset();
    idle();
    rst_n = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    tick(); tick();
    h2f_q.delete(); f2h_q.delete();
    exp_rd = 0; exp_wr = 0;
  endtask

  task automatic test_reset();
    idle();
    rst_n = 1'b0;
    tick(); tick();
    #2;
    total_cnt++;
    if ({ft_rxf_n, ft_txe_n, h2f_ready, f2h_valid} !== 4'b1100) $display("FAIL reset_flags got %b want 1100", {ft_rxf_n, ft_txe_n, h2f_ready, f2h_valid});
    else pass_cnt++;
    total_cnt++;
    if ({err, rd_count, wr_count} !== '0) $display("FAIL reset_regs err=%h rd=%0d wr=%0d want 0", err, rd_count, wr_count);
    else pass_cnt++;
    ft_oe_n = 1'b0;
    #1;
    total_cnt++;
    if ({ft_be, ft_data} !== 18'h0) $display("FAIL reset_bus got %h want 0", {ft_be, ft_data});
    else pass_cnt++;
    ft_oe_n = 1'b1;
    rst_n = 1'b1;
    tick(); tick();
    total_cnt++;
    if ({ft_rxf_n, ft_txe_n, h2f_ready} !== 3'b101) $display("FAIL post_reset_flags got %b want 101", {ft_rxf_n, ft_txe_n, h2f_ready});
    else pass_cnt++;
    exp_rd = 0; exp_wr = 0;
  endtask

  task automatic test_h2f_read();
    logic [15:0] words [4];
    ft600_word_t w;
    words[0] = 16'h1111; words[1] = 16'h1102; words[2] = 16'h1103; words[3] = 16'h1104;
    for (int i = 0; i < 4; i++) begin
      h2f_data = words[i]; h2f_be = 2'b11; h2f_valid = 1'b1;
      h2f_q.push_back({2'b11, words[i]});
      if (i == 0) begin
        total_cnt++;
        if (ft_rxf_n !== 1'b1) $display("FAIL rxf_before_push got %b want 1", ft_rxf_n);
        else pass_cnt++;
      end
      tick();
      if (i == 0) begin
        total_cnt++;
        if (ft_rxf_n !== 1'b0) $display("FAIL rxf_after_push got %b want 0", ft_rxf_n);
        else pass_cnt++;
      end
    end
    h2f_valid = 1'b0;
    ft_oe_n = 1'b0;
    for (int i = 0; i < 4; i++) begin
      ft_rd_n = 1'b0;
      #2;
      w = h2f_q.pop_front();
      total_cnt++;
      if ({ft_be, ft_data} !== w) $display("FAIL h2f_read[%0d] got %h want %h", i, {ft_be, ft_data}, w);
      else pass_cnt++;
      exp_rd++;
      tick();
    end
    ft_rd_n = 1'b1; ft_oe_n = 1'b1;
    total_cnt++;
    if (ft_rxf_n !== 1'b1) $display("FAIL rxf_after_drain got %b want 1", ft_rxf_n);
    else pass_cnt++;
    total_cnt++;
    if ({rd_count, err} !== {exp_rd, 4'h0}) $display("FAIL h2f_counts rd=%0d err=%h want rd=%0d err=0", rd_count, err, exp_rd);
    else pass_cnt++;
  endtask

  task automatic test_f2h_write();
    ft600_word_t w;
    f2h_ready = 1'b0; ft_oe_n = 1'b1;
    total_cnt++;
    if (ft_txe_n !== 1'b0) $display("FAIL txe_before_write got %b want 0", ft_txe_n);
    else pass_cnt++;
    for (int i = 0; i < 16; i++) begin
      m_data = 16'hA000 + 16'(i); m_be = 2'b11; ft_wr_n = 1'b0;
      f2h_q.push_back({m_be, m_data});
      exp_wr++;
      tick();
    end
    ft_wr_n = 1'b1;
    f2h_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      #2;
      w = f2h_q.pop_front();
      total_cnt++;
      if (!f2h_valid || f2h_data !== w) $display("FAIL f2h_word[%0d] got v=%b %h want %h", i, f2h_valid, f2h_data, w);
      else pass_cnt++;
      tick();
    end
    f2h_ready = 1'b0;
    total_cnt++;
    if ({f2h_valid, wr_count, err} !== {1'b0, exp_wr, 4'h0}) $display("FAIL f2h_end v=%b wr=%0d err=%h want v=0 wr=%0d err=0", f2h_valid, wr_count, err, exp_wr);
    else pass_cnt++;
  endtask

  task automatic test_overrun();
    int n;
    ft600_word_t w;
    do_reset();
    f2h_ready = 1'b0; ft_oe_n = 1'b1;
    n = 0;
    while (!ft_txe_n && n < DEPTH + 4) begin
      m_data = 16'($urandom); m_be = 2'($urandom); ft_wr_n = 1'b0;
      f2h_q.push_back({m_be, m_data});
      exp_wr++; n++;
      tick();
    end
    ft_wr_n = 1'b1;
    total_cnt++;
    if (n !== DEPTH - MARGIN) $display("FAIL txe_threshold words=%0d want %0d", n, DEPTH - MARGIN);
    else pass_cnt++;
    total_cnt++;
    if (err !== 4'h0) $display("FAIL err_before_overrun got %h want 0", err);
    else pass_cnt++;
    m_data = 16'hDEAD; m_be = 2'b11; ft_wr_n = 1'b0;
    tick();
    ft_wr_n = 1'b1;
    total_cnt++;
    if ({err, wr_count} !== {4'(1 << ERR_OVERRUN), exp_wr}) $display("FAIL overrun err=%h wr=%0d want err=%h wr=%0d", err, wr_count, 4'(1 << ERR_OVERRUN), exp_wr);
    else pass_cnt++;
    f2h_ready = 1'b1;
    for (int i = 0; i < n; i++) begin
      #2;
      w = f2h_q.pop_front();
      total_cnt++;
      if (!f2h_valid || f2h_data !== w) $display("FAIL overrun_drain[%0d] got v=%b %h want %h", i, f2h_valid, f2h_data, w);
      else pass_cnt++;
      tick();
    end
    f2h_ready = 1'b0;
    total_cnt++;
    if ({f2h_valid, ft_txe_n, err} !== {2'b00, 4'(1 << ERR_OVERRUN)}) $display("FAIL overrun_after v=%b txe=%b err=%h", f2h_valid, ft_txe_n, err);
    else pass_cnt++;
  endtask

  task automatic test_protocol_errs();
    ft600_word_t w;
    do_reset();
    for (int i = 0; i < 2; i++) begin
      h2f_data = 16'($urandom); h2f_be = 2'b11; h2f_valid = 1'b1;
      h2f_q.push_back({h2f_be, h2f_data});
      tick();
    end
    h2f_valid = 1'b0;
    ft_rd_n = 1'b0; ft_oe_n = 1'b1;
    tick();
    ft_rd_n = 1'b1;
    total_cnt++;
    if ({err, rd_count, ft_rxf_n} !== {4'(1 << ERR_RD_NO_OE), 32'd0, 1'b0}) $display("FAIL rd_no_oe err=%h rd=%0d rxf=%b", err, rd_count, ft_rxf_n);
    else pass_cnt++;
    ft_oe_n = 1'b0;
    for (int i = 0; i < 2; i++) begin
      ft_rd_n = 1'b0;
      #2;
      w = h2f_q.pop_front();
      total_cnt++;
      if ({ft_be, ft_data} !== w) $display("FAIL h2f_intact[%0d] got %h want %h", i, {ft_be, ft_data}, w);
      else pass_cnt++;
      exp_rd++;
      tick();
    end
    ft_rd_n = 1'b1;
    ft_wr_n = 1'b0;
    tick();
    ft_wr_n = 1'b1;
    total_cnt++;
    if ({err, wr_count, f2h_valid} !== {4'((1 << ERR_RD_NO_OE) | (1 << ERR_WR_OE)), 32'd0, 1'b0}) $display("FAIL wr_oe err=%h wr=%0d v=%b", err, wr_count, f2h_valid);
    else pass_cnt++;
    ft_rd_n = 1'b0;
    tick();
    ft_rd_n = 1'b1; ft_oe_n = 1'b1;
    tick(); tick();
    total_cnt++;
    if ({err, rd_count} !== {4'((1 << ERR_RD_NO_OE) | (1 << ERR_WR_OE) | (1 << ERR_UNDERRUN)), exp_rd}) $display("FAIL underrun err=%h rd=%0d want rd=%0d", err, rd_count, exp_rd);
    else pass_cnt++;
    do_reset();
    total_cnt++;
    if (err !== 4'h0) $display("FAIL err_cleared got %h want 0", err);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid_burst();
    ft600_word_t w;
    do_reset();
    for (int i = 0; i < 100; i++) begin
      h2f_data = 16'($urandom); h2f_be = 2'($urandom); h2f_valid = 1'b1;
      h2f_q.push_back({h2f_be, h2f_data});
      tick();
    end
    h2f_valid = 1'b0;
    ft_oe_n = 1'b0; ft_rd_n = 1'b0;
    for (int i = 0; i < 50; i++) begin
      #2;
      w = h2f_q.pop_front();
      if ({ft_be, ft_data} !== w) begin
        total_cnt++;
        $display("FAIL burst_read[%0d] got %h want %h", i, {ft_be, ft_data}, w);
      end
      tick();
    end
    rst_n = 1'b0;
    tick();
    total_cnt++;
    if ({ft_rxf_n, ft_txe_n, h2f_ready, err, rd_count, wr_count} !== {3'b110, 4'h0, 64'd0}) $display("FAIL mid_reset rxf=%b txe=%b rdy=%b err=%h rd=%0d wr=%0d", ft_rxf_n, ft_txe_n, h2f_ready, err, rd_count, wr_count);
    else pass_cnt++;
    tick();
    rst_n = 1'b1; ft_rd_n = 1'b1; ft_oe_n = 1'b1;
    tick(); tick();
    total_cnt++;
    if ({ft_rxf_n, ft_txe_n, err, rd_count} !== {2'b10, 4'h0, 32'd0}) $display("FAIL after_mid_reset rxf=%b txe=%b err=%h rd=%0d", ft_rxf_n, ft_txe_n, err, rd_count);
    else pass_cnt++;
    h2f_q.delete(); exp_rd = 0; exp_wr = 0;
  endtask

  task automatic test_loopback();
    int pushed, rd_got, wr_sent, f2h_got, cyc;
    ft600_word_t w;
    do_reset();
    pushed = 0; rd_got = 0; wr_sent = 0; f2h_got = 0; cyc = 0;
    while ((rd_got < N_LOOP || f2h_got < N_LOOP) && cyc < 60000) begin
      h2f_valid = (pushed < N_LOOP) && ($urandom_range(0, 3) != 0);
      h2f_data = 16'($urandom); h2f_be = 2'($urandom);
      // alternate slow and fast draining so the F2H side also reaches its threshold
      f2h_ready = (cyc & 2048) != 0 ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 1) == 1);
      ft_rd_n = 1'b1; ft_wr_n = 1'b1; ft_oe_n = 1'b1;
      if ($urandom_range(0, 1) == 0) begin
        if (!ft_rxf_n) begin
          ft_oe_n = 1'b0;
          ft_rd_n = ($urandom_range(0, 4) == 0);
        end
      end else if (!ft_txe_n && wr_sent < N_LOOP) begin
        ft_wr_n = $urandom_range(0, 1) == 1;
        m_data = 16'($urandom); m_be = 2'($urandom);
      end
      #2;
      if (h2f_valid && h2f_ready) begin
        h2f_q.push_back({h2f_be, h2f_data});
        pushed++;
      end
      if (!ft_rd_n && !ft_oe_n) begin
        total_cnt++;
        if (h2f_q.size() == 0) $display("FAIL loop_h2f_extra got %h want none", {ft_be, ft_data});
        else begin
          w = h2f_q.pop_front();
          if ({ft_be, ft_data} !== w) $display("FAIL loop_h2f[%0d] got %h want %h", rd_got, {ft_be, ft_data}, w);
          else pass_cnt++;
        end
        rd_got++; exp_rd++;
      end
      if (!ft_wr_n) begin
        f2h_q.push_back({m_be, m_data});
        wr_sent++; exp_wr++;
      end
      if (f2h_valid && f2h_ready) begin
        total_cnt++;
        if (f2h_q.size() == 0) $display("FAIL loop_f2h_extra got %h want none", f2h_data);
        else begin
          w = f2h_q.pop_front();
          if (f2h_data !== w) $display("FAIL loop_f2h[%0d] got %h want %h", f2h_got, f2h_data, w);
          else pass_cnt++;
        end
        f2h_got++;
      end
      cyc++;
      tick();
    end
    idle();
    total_cnt++;
    if (rd_got != N_LOOP || f2h_got != N_LOOP) $display("FAIL loop_done rd=%0d f2h=%0d want %0d each (cycles=%0d)", rd_got, f2h_got, N_LOOP, cyc);
    else pass_cnt++;
    total_cnt++;
    if ({err, rd_count, wr_count} !== {4'h0, exp_rd, exp_wr}) $display("FAIL loop_counts err=%h rd=%0d wr=%0d want err=0 rd=%0d wr=%0d", err, rd_count, wr_count, exp_rd, exp_wr);
    else pass_cnt++;
    total_cnt++;
    if ({ft_rxf_n, f2h_valid} !== 2'b10) $display("FAIL loop_empty rxf=%b v=%b want rxf=1 v=0", ft_rxf_n, f2h_valid);
    else pass_cnt++;
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    idle();
    exp_rd = 0; exp_wr = 0;
    test_reset();
    test_h2f_read();
    test_f2h_write();
    test_overrun();
    test_protocol_errs();
    test_reset_mid_burst();
    test_loopback();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
